fp16_to_int16_converter: RTL
============================

Name: fp16_to_int16_converter

Overview:
- Multicycle converter from IEEE-754 half precision to a 16-bit two's-complement signed integer. It is the reverse direction of the half-precision add/sub unit.
- Sits on the FPU result path. It takes FP16 operands, or results of the add/sub unit, and hands integer values to integer datapaths.
- Uses the same start/done/OFUF conventions as the add/sub unit. Shifts one bit per cycle.

Parameters:
SAT_ON_OVF, 1, result on overflow: 1 = saturate to 16'h7FFF / 16'h8000 by sign; 0 = force 16'h0000.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
start  input  1  request; sampled only in IDLE
X  input  16  FP16 operand {sign, exp[4:0], frac[9:0]}; sampled on the accepting edge
result  output  16  signed integer; held until the next accepted start
done  output  1  one-cycle pulse when result and OFUF are valid
busy  output  1  high from the accepting edge until the done edge
OFUF  output  2  2'b10 = overflow/Inf/NaN; 2'b01 = nonzero input produced 0; 2'b00 = ok

Behaviour:
- Reset (async): state=IDLE; result=0, done=0, busy=0, OFUF=0; all working registers cleared.
- Reset asserted mid-operation aborts the conversion and emits no done pulse.
- Operand decode:
  - s=X[15], E=X[14:10], e=E-15 (signed).
  - M={1,X[9:0]}, 11 bits, held in a 27-bit accumulator acc.
  - Guard bit g and sticky bit st are cleared on load.
- IDLE:
  - start=1 latches X, sets busy, and moves to CLASSIFY.
  - start while busy is ignored; no queueing.
- CLASSIFY (1 cycle), priority order:
  - X[14:0]==0 -> result 0, OFUF 00, go DONE.
  - E==0 (subnormal) -> result 0, OFUF 01, go DONE.
  - E==31 (Inf/NaN) -> overflow result, OFUF 10, go DONE.
  - e>15 -> overflow result, OFUF 10, go DONE.
  - e<0: without the optional feature -> result 0, OFUF 01, go DONE.
  - Otherwise: load n=|e-10| and direction (left if e>=10, else right). Go SHIFT if n>0, else FINISH.
- SHIFT (n cycles, one bit per cycle):
  - Left: acc<<=1.
  - Right: st<=st|g; g<=acc[0]; acc>>=1.
  - Decrement n; go FINISH when n reaches 0.
- FINISH (1 cycle):
  - Optional rounding step (see Optional Feature).
  - Range check: positive needs mag<=32767; negative needs mag<=32768. Out of range -> overflow result, OFUF 10.
  - Otherwise result = s ? -mag : mag. OFUF=01 if mag==0, else 00.
  - Go DONE.
- DONE:
  - result/OFUF registered; done=1 for exactly one cycle; busy=0.
  - Return to IDLE. start may be accepted on the edge after done.
- Latency, with start accepted at edge k:
  - Special cases: done high after edge k+2.
  - Normal path: done high after edge k+3+n, where n=|e-10| (0..10; 11 with the feature).
- Exact boundary: -32768.0 (0xF800) converts to 16'h8000 with no overflow. +32768.0 (0x7800) overflows.
- Default rounding: truncate toward zero (g and st ignored).

Optional Feature:
ROUND_NEAREST_EN
- Defined:
  - FINISH applies round-to-nearest-even on magnitude: mag += g & (st | acc[0]), before the range check.
  - e==-1 takes the normal path with n=11 instead of the CLASSIFY shortcut.
  - A round-up to 32768 on a positive input is overflow (OFUF 10).
- Undefined: truncation only; g/st logic and the n=11 case are compiled out.

Test Plan:
- X=0x3C00 (1.0), start at edge k -> done after edge k+13, result 16'h0001, OFUF 00, busy low after done.
- X=0xC500 (-5.0, e=2, n=8) -> result 16'hFFFB, OFUF 00. Then X=0xF800 -> 16'h8000, OFUF 00. Then X=0x7800 -> 16'h7FFF, OFUF 10 (16'h0000 when SAT_ON_OVF=0).
- X=0x7C00 (+Inf) -> 16'h7FFF, OFUF 10, done after edge k+2. X=0x0001 (subnormal) -> 16'h0000, OFUF 01. X=0x8000 (-0) -> 0, OFUF 00.
- X=0x3E00 (1.5) -> 1 truncating, 2 with ROUND_NEAREST_EN. X=0x4100 (2.5) -> 2 in both builds. X=0x3800 (0.5) -> 0, OFUF 01 in both builds; the ROUND_NEAREST_EN build takes the n=11 path.
- X=0x7BFF (65504) -> overflow, OFUF 10. X=0xD3FF (-63.97) -> 16'hFFC1 (-63) truncating, 16'hFFC0 (-64) with ROUND_NEAREST_EN.
- Start 0x3C00, pulse start with X=0x4000 during SHIFT -> ignored, result 1. Assert reset mid-SHIFT -> outputs 0, no done, and the next start converts correctly.

Source files
------------

// File: rtl/fp16_to_int16_converter_if.sv
// rtl/fp16_to_int16_converter_if.sv - start/done handshake and data bundle for the FP16-to-INT16 converter
interface fp16_to_int16_converter_if;
    logic        start;
    logic [15:0] X;
    logic [15:0] result;
    logic        done;
    logic        busy;
    logic [1:0]  OFUF;

    // Requester side: issues start/X, observes the conversion outcome.
    modport master (
        output start,
        output X,
        input  result,
        input  done,
        input  busy,
        input  OFUF
    );

    // Converter side.
    modport slave (
        input  start,
        input  X,
        output result,
        output done,
        output busy,
        output OFUF
    );
endinterface

// File: rtl/fp16_to_int16_converter.sv
// rtl/fp16_to_int16_converter.sv - multicycle FP16 to signed INT16 converter, one shift bit per cycle (option: ROUND_NEAREST_EN)
module fp16_to_int16_converter #(
    parameter bit SAT_ON_OVF = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    fp16_to_int16_converter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        SHIFT,
        FINISH,
        DONE
    } state_t;

`ifdef ROUND_NEAREST_EN
    // e == -1 still reaches the shifter so that 0.5..1.0 can round up.
    localparam logic [4:0] MIN_NORMAL_EXP = 5'd14;
`else
    localparam logic [4:0] MIN_NORMAL_EXP = 5'd15;
`endif

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [26:0] acc_q, acc_d;
    logic [3:0]  n_q, n_d;
    logic        left_q, left_d;
    logic [15:0] pres_q, pres_d;
    logic [1:0]  pof_q, pof_d;
    logic [15:0] result_q, result_d;
    logic [1:0]  ofuf_q, ofuf_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
`ifdef ROUND_NEAREST_EN
    logic        g_q, g_d;
    logic        st_q, st_d;
`endif

    logic        sign_w;
    logic [4:0]  exp_w;
    logic [15:0] ovf_res_w;
    logic        rnd_w;
    logic [26:0] mag_w;

    assign sign_w    = x_q[15];
    assign exp_w     = x_q[14:10];
    assign ovf_res_w = SAT_ON_OVF ? (sign_w ? 16'h8000 : 16'h7FFF) : 16'h0000;
`ifdef ROUND_NEAREST_EN
    assign rnd_w     = g_q & (st_q | acc_q[0]);
`else
    assign rnd_w     = 1'b0;
`endif
    assign mag_w     = acc_q + {26'd0, rnd_w};

    assign bus.result = result_q;
    assign bus.OFUF   = ofuf_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            x_q      <= '0;
            acc_q    <= '0;
            n_q      <= '0;
            left_q   <= 1'b0;
            pres_q   <= '0;
            pof_q    <= '0;
            result_q <= '0;
            ofuf_q   <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef ROUND_NEAREST_EN
            g_q      <= 1'b0;
            st_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            acc_q    <= acc_d;
            n_q      <= n_d;
            left_q   <= left_d;
            pres_q   <= pres_d;
            pof_q    <= pof_d;
            result_q <= result_d;
            ofuf_q   <= ofuf_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef ROUND_NEAREST_EN
            g_q      <= g_d;
            st_q     <= st_d;
`endif
        end
    end

    // Next-state and datapath updates for classify / shift / finish sequencing.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        acc_d    = acc_q;
        n_d      = n_q;
        left_d   = left_q;
        pres_d   = pres_q;
        pof_d    = pof_q;
        result_d = result_q;
        ofuf_d   = ofuf_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
`ifdef ROUND_NEAREST_EN
        g_d      = g_q;
        st_d     = st_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d     = bus.X;
                    acc_d   = {16'd0, 1'b1, bus.X[9:0]};
                    busy_d  = 1'b1;
                    state_d = CLASSIFY;
`ifdef ROUND_NEAREST_EN
                    g_d     = 1'b0;
                    st_d    = 1'b0;
`endif
                end
            end

            CLASSIFY: begin
                state_d = DONE;
                if (x_q[14:0] == 15'd0) begin
                    pres_d = 16'h0000;
                    pof_d  = 2'b00;
                end else if (exp_w == 5'd0) begin
                    pres_d = 16'h0000;
                    pof_d  = 2'b01;
                end else if (exp_w == 5'd31) begin
                    // Inf/NaN; also the only encoding with e > 15.
                    pres_d = ovf_res_w;
                    pof_d  = 2'b10;
                end else if (exp_w < MIN_NORMAL_EXP) begin
                    pres_d = 16'h0000;
                    pof_d  = 2'b01;
                end else begin
                    // Integer point sits 10 bits above the mantissa LSB (E == 25).
                    if (exp_w >= 5'd25) begin
                        left_d = 1'b1;
                        n_d    = 4'(exp_w - 5'd25);
                    end else begin
                        left_d = 1'b0;
                        n_d    = 4'(5'd25 - exp_w);
                    end
                    state_d = (exp_w == 5'd25) ? FINISH : SHIFT;
                end
            end

            SHIFT: begin
                if (left_q) begin
                    acc_d = acc_q << 1;
                end else begin
                    acc_d = acc_q >> 1;
`ifdef ROUND_NEAREST_EN
                    g_d   = acc_q[0];
                    st_d  = st_q | g_q;
`endif
                end
                n_d = n_q - 4'd1;
                if (n_q == 4'd1) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                state_d = DONE;
                if ((!sign_w && mag_w > 27'd32767) || (sign_w && mag_w > 27'd32768)) begin
                    pres_d = ovf_res_w;
                    pof_d  = 2'b10;
                end else begin
                    pres_d = sign_w ? (16'd0 - mag_w[15:0]) : mag_w[15:0];
                    pof_d  = (mag_w == 27'd0) ? 2'b01 : 2'b00;
                end
            end

            DONE: begin
                result_d = pres_q;
                ofuf_d   = pof_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
